// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types for the memory port arbiter. It holds the default memory
//   geometry, the requester identity and the response tag that travels
//   down the read-latency pipe.
package mem_arb_pkg;

  localparam int DEFAULT_ADDR_W = 13;
  localparam int DEFAULT_DATA_W = 16;

  // Identity of the unit that owns an access.
  typedef enum logic [0:0] {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // One pipe slot: a read in flight and the unit that gets its data.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } resp_tag_t;

  localparam resp_tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_FETCH};

  // Build the tag for the access issued this cycle. Writes and idle
  // cycles go down the pipe as empty slots.
  function automatic resp_tag_t make_tag(input logic is_read, input owner_e who);
    resp_tag_t t;
    t.valid = is_read;
    t.owner = who;
    return t;
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// mem_resp_pipe
//   Carries a {valid, owner} tag alongside each access for MEM_LATENCY
//   clocks, then registers the memory read data into the owner's
//   rvalid/rdata pair. rdata holds its last value while rvalid is low.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   issue_tag             tag of the access the memory samples this edge
//   mem_dout              memory read data (douta)
//   if_rvalid, if_rdata   fetch response
//   d_rvalid,  d_rdata    data-unit response
module mem_resp_pipe
  import mem_arb_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int MEM_LATENCY = 1              // legal range 1..3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  resp_tag_t         issue_tag,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata
);

  resp_tag_t         tag_r [MEM_LATENCY];
  resp_tag_t         tail_s;
  logic              tail_fetch_s;
  logic              tail_data_s;
  logic              if_rvalid_r;
  logic              d_rvalid_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;

  // Tag shift register; stage 0 is loaded on the edge that samples the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        tag_r[i] <= TAG_IDLE;
      end
    end else begin
      tag_r[0] <= issue_tag;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // The last stage lines up with valid douta for the access it describes.
  always_comb begin
    tail_s       = tag_r[MEM_LATENCY-1];
    tail_fetch_s = 1'b0;
    tail_data_s  = 1'b0;
    if (tail_s.valid) begin
      tail_fetch_s = (tail_s.owner == OWN_FETCH);
      tail_data_s  = (tail_s.owner == OWN_DATA);
    end else begin
      tail_fetch_s = 1'b0;
      tail_data_s  = 1'b0;
    end
  end

  // Response registers: a one-cycle rvalid pulse, data captured only for the owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      if_rdata_r  <= '0;
      d_rdata_r   <= '0;
    end else begin
      if_rvalid_r <= tail_fetch_s;
      d_rvalid_r  <= tail_data_s;
      if (tail_fetch_s) begin
        if_rdata_r <= mem_dout;
      end
      if (tail_data_s) begin
        d_rdata_r <= mem_dout;
      end
    end
  end

  assign if_rvalid = if_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign d_rvalid  = d_rvalid_r;
  assign d_rdata   = d_rdata_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port block memory between the instruction-fetch unit
//   and the data/stack-spill unit. One access is issued per cycle; on a tie
//   the unit that did not win last time is granted. Read data is steered
//   back to its requester after the memory read latency.
// Ports:
//   clk, rst_n                      clock (also memory clka), async active-low reset
//   if_req, if_addr                 fetch read request
//   if_gnt                          fetch accepted this cycle (combinational)
//   if_rvalid, if_rdata             fetch response
//   d_req, d_we, d_addr, d_wdata    data-unit request (read or write)
//   d_gnt                           data request accepted this cycle (combinational)
//   d_rvalid, d_rdata               data-unit read response
//   mem_we, mem_addr, mem_din       memory wea/addra/dina
//   mem_dout                        memory douta
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  owner_e            last_winner_r;
  logic              grant_fetch_s;
  logic              grant_data_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_din_s;
  resp_tag_t         issue_tag_s;

  // Round-robin grant: a lone requester always wins, a tie goes to the
  // unit that did not win the previous grant.
  always_comb begin
    grant_fetch_s = 1'b0;
    grant_data_s  = 1'b0;
    if (if_req && d_req) begin
      if (last_winner_r == OWN_DATA) begin
        grant_fetch_s = 1'b1;
      end else begin
        grant_data_s = 1'b1;
      end
    end else if (if_req) begin
      grant_fetch_s = 1'b1;
    end else if (d_req) begin
      grant_data_s = 1'b1;
    end else begin
      grant_fetch_s = 1'b0;
      grant_data_s  = 1'b0;
    end
  end

  // Last-winner register; only moves when something is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner_r <= OWN_DATA;
    end else if (grant_fetch_s) begin
      last_winner_r <= OWN_FETCH;
    end else if (grant_data_s) begin
      last_winner_r <= OWN_DATA;
    end
  end

  // Memory drive from the granted port; the memory samples it on the next edge.
  // Fetch is read-only, so a fetch grant never writes.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_din_s   = '0;
    issue_tag_s = TAG_IDLE;
    if (grant_fetch_s) begin
      mem_addr_s  = if_addr;
      issue_tag_s = make_tag(1'b1, OWN_FETCH);
    end else if (grant_data_s) begin
      mem_we_s    = d_we;
      mem_addr_s  = d_addr;
      mem_din_s   = d_wdata;
      issue_tag_s = make_tag(!d_we, OWN_DATA);
    end else begin
      mem_we_s    = 1'b0;
      mem_addr_s  = '0;
      mem_din_s   = '0;
      issue_tag_s = TAG_IDLE;
    end
  end

  assign if_gnt   = grant_fetch_s;
  assign d_gnt    = grant_data_s;
  assign mem_we   = mem_we_s;
  assign mem_addr = mem_addr_s;
  assign mem_din  = mem_din_s;

  mem_resp_pipe #(
    .DATA_W      (DATA_W),
    .MEM_LATENCY (MEM_LATENCY)
  ) u_resp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_tag (issue_tag_s),
    .mem_dout  (mem_dout),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 2) share
// the same request stimulus, each with its own behavioural write-first
// memory. Expected read responses are queued at grant time and retired by
// per-instance monitors.
module tb_mem_port_arbiter;

  typedef struct {
    logic        own_d;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [12:0] if_addr, d_addr;
  logic [15:0] d_wdata;

  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_we1;
  logic [15:0] if_rdata1, d_rdata1, mem_din1, mem_dout1;
  logic [12:0] mem_addr1;
  logic        if_gnt2, if_rvalid2, d_gnt2, d_rvalid2, mem_we2;
  logic [15:0] if_rdata2, d_rdata2, mem_din2, mem_dout2;
  logic [12:0] mem_addr2;

  logic [15:0] mem1 [8192];
  logic [15:0] mem2 [8192];
  logic [15:0] ref_mem [8192];
  logic [15:0] dout1, d2a, d2b;
  logic        loaded = 1'b0;

  exp_t q1[$];
  exp_t q2[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_W(13), .DATA_W(16), .MEM_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_dout(mem_dout1)
  );

  mem_port_arbiter #(.ADDR_W(13), .DATA_W(16), .MEM_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt2),
    .if_rvalid(if_rvalid2), .if_rdata(if_rdata2),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_din(mem_din2), .mem_dout(mem_dout2)
  );

  function automatic logic [15:0] init_val(input int a);
    if (a <= 11) return 16'(a);
    else if (a <= 19) return 16'((a - 11) << 12);
    else return 16'h0000;
  endfunction

  // Behavioural block memories, write-first; mem2 has one extra output stage.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 8192; i++) begin
        mem1[i] <= init_val(i);
        mem2[i] <= init_val(i);
      end
      loaded <= 1'b1;
    end else begin
      if (mem_we1) begin
        mem1[mem_addr1] <= mem_din1;
        dout1 <= mem_din1;
      end else begin
        dout1 <= mem1[mem_addr1];
      end
      if (mem_we2) begin
        mem2[mem_addr2] <= mem_din2;
        d2a <= mem_din2;
      end else begin
        d2a <= mem2[mem_addr2];
      end
      d2b <= d2a;
    end
  end

  assign mem_dout1 = dout1;
  assign mem_dout2 = d2b;

  // Scoreboard for the latency-1 instance.
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] rd;
    if (rst_n) begin
      if (if_rvalid1 || d_rvalid1) begin
        total++;
        rd = d_rvalid1 ? d_rdata1 : if_rdata1;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL resp1_unexpected: cyc=%0d if_rvalid=%b d_rvalid=%b data=%h", cyc, if_rvalid1, d_rvalid1, rd);
        end else begin
          e = q1.pop_front();
          if ((if_rvalid1 && d_rvalid1) || d_rvalid1 !== e.own_d || rd !== e.data || cyc != e.due)
            begin
              bad++;
              $display("FAIL resp1: got d=%b data=%h cyc=%0d, want d=%b data=%h cyc=%0d",
                       d_rvalid1, rd, cyc, e.own_d, e.data, e.due);
            end
        end
      end else if (q1.size() > 0 && q1[0].due <= cyc) begin
        total++;
        bad++;
        e = q1.pop_front();
        $display("FAIL resp1_missing: no rvalid at cyc=%0d, want data=%h", cyc, e.data);
      end
    end
  end

  // Scoreboard for the latency-2 instance.
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] rd;
    if (rst_n) begin
      if (if_rvalid2 || d_rvalid2) begin
        total++;
        rd = d_rvalid2 ? d_rdata2 : if_rdata2;
        if (q2.size() == 0) begin
          bad++;
          $display("FAIL resp2_unexpected: cyc=%0d if_rvalid=%b d_rvalid=%b data=%h", cyc, if_rvalid2, d_rvalid2, rd);
        end else begin
          e = q2.pop_front();
          if ((if_rvalid2 && d_rvalid2) || d_rvalid2 !== e.own_d || rd !== e.data || cyc != e.due)
            begin
              bad++;
              $display("FAIL resp2: got d=%b data=%h cyc=%0d, want d=%b data=%h cyc=%0d",
                       d_rvalid2, rd, cyc, e.own_d, e.data, e.due);
            end
        end
      end else if (q2.size() > 0 && q2[0].due <= cyc) begin
        total++;
        bad++;
        e = q2.pop_front();
        $display("FAIL resp2_missing: no rvalid at cyc=%0d, want data=%h", cyc, e.data);
      end
    end
  end

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 13'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 13'd0; d_wdata = 16'd0;
  endtask

  // Called at the negedge of the request cycle: grant edge is the next
  // posedge, rvalid is seen at the negedge after edge grant+latency.
  task automatic push_exp(input logic own_d, input logic [15:0] data);
    q1.push_back('{own_d: own_d, data: data, due: cyc + 2});
    q2.push_back('{own_d: own_d, data: data, due: cyc + 3});
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    idle_inputs();
    q1.delete();
    q2.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    @(posedge clk);
    #1 idle_inputs();
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++;
    if ({if_rvalid1, d_rvalid1, if_rvalid2, d_rvalid2} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_rvalid: got %b want 0000", {if_rvalid1, d_rvalid1, if_rvalid2, d_rvalid2});
    end
    total++;
    if ({if_rdata1, d_rdata1, if_rdata2, d_rdata2} !== 64'd0) begin
      bad++;
      $display("FAIL reset_rdata: got %h want 0", {if_rdata1, d_rdata1, if_rdata2, d_rdata2});
    end
    total++;
    if ({if_gnt1, d_gnt1, mem_we1, mem_addr1, mem_din1} !== 32'd0) begin
      bad++;
      $display("FAIL idle_drive: got gnt=%b%b we=%b addr=%h din=%h want all 0",
               if_gnt1, d_gnt1, mem_we1, mem_addr1, mem_din1);
    end
  endtask

  task automatic test_fetch_reads();
    for (int i = 0; i <= 11; i++) begin
      @(posedge clk);
      #1 if_req = 1'b1; if_addr = 13'(i);
      @(negedge clk);
      total++;
      if ({if_gnt1, d_gnt1, if_gnt2, d_gnt2, mem_we1, mem_addr1} !== {5'b10100, 13'(i)}) begin
        bad++;
        $display("FAIL fetch_gnt[%0d]: got gnt=%b%b%b%b we=%b addr=%h want 1010 0 %h",
                 i, if_gnt1, d_gnt1, if_gnt2, d_gnt2, mem_we1, mem_addr1, i);
      end
      push_exp(1'b0, ref_mem[i]);
    end
    drain(5);
  endtask

  task automatic test_data_reads();
    for (int a = 12; a <= 19; a++) begin
      @(posedge clk);
      #1 d_req = 1'b1; d_we = 1'b0; d_addr = 13'(a);
      @(negedge clk);
      total++;
      if ({if_gnt1, d_gnt1, if_gnt2, d_gnt2, mem_we1, mem_addr1} !== {5'b01010, 13'(a)}) begin
        bad++;
        $display("FAIL data_gnt[%0d]: got gnt=%b%b%b%b we=%b addr=%h want 0101 0 %h",
                 a, if_gnt1, d_gnt1, if_gnt2, d_gnt2, mem_we1, mem_addr1, a);
      end
      push_exp(1'b1, ref_mem[a]);
    end
    drain(5);
    total++;
    if (if_rdata1 !== 16'd11 || d_rdata2 !== 16'h8000) begin
      bad++;
      $display("FAIL rdata_hold: got if_rdata=%h d_rdata2=%h want 000b 8000", if_rdata1, d_rdata2);
    end
  endtask

  task automatic test_back_to_back_tie();
    logic exp_f;
    apply_reset();
    exp_f = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 if_req = 1'b1; if_addr = 13'd3; d_req = 1'b1; d_we = 1'b0; d_addr = 13'd14;
      @(negedge clk);
      total++;
      if ({if_gnt1, d_gnt1, if_gnt2, d_gnt2} !== {exp_f, !exp_f, exp_f, !exp_f} ||
          mem_addr1 !== (exp_f ? 13'd3 : 13'd14)) begin
        bad++;
        $display("FAIL tie[%0d]: got gnt=%b%b%b%b addr=%h want fetch=%b", i,
                 if_gnt1, d_gnt1, if_gnt2, d_gnt2, mem_addr1, exp_f);
      end
      push_exp(!exp_f, exp_f ? ref_mem[3] : ref_mem[14]);
      exp_f = !exp_f;
    end
    drain(5);
  endtask

  task automatic test_read_after_write();
    @(posedge clk);
    #1 d_req = 1'b1; d_we = 1'b1; d_addr = 13'd5; d_wdata = 16'hBEEF;
    @(negedge clk);
    total++;
    if ({d_gnt1, if_gnt1, mem_we1, mem_addr1, mem_din1} !== {3'b101, 13'd5, 16'hBEEF}) begin
      bad++;
      $display("FAIL write_drive: got gnt=%b%b we=%b addr=%h din=%h want 10 1 0005 beef",
               d_gnt1, if_gnt1, mem_we1, mem_addr1, mem_din1);
    end
    ref_mem[5] = 16'hBEEF;
    @(posedge clk);
    #1 idle_inputs(); if_req = 1'b1; if_addr = 13'd5;
    @(negedge clk);
    total++;
    if ({if_gnt1, mem_we1} !== 2'b10) begin
      bad++;
      $display("FAIL raw_fetch_gnt: got gnt=%b we=%b want 1 0", if_gnt1, mem_we1);
    end
    push_exp(1'b0, ref_mem[5]);
    drain(5);
  endtask

  task automatic test_reset_inflight();
    @(posedge clk);
    #1 if_req = 1'b1; if_addr = 13'd2;
    @(negedge clk);
    total++;
    if (if_gnt1 !== 1'b1) begin
      bad++;
      $display("FAIL inflight_gnt: got %b want 1", if_gnt1);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    idle_inputs();
    q1.delete();
    q2.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({if_rvalid1, d_rvalid1, if_rvalid2, d_rvalid2} !== 4'b0000) begin
        bad++;
        $display("FAIL dropped_read[%0d]: got rvalid=%b want 0000", i,
                 {if_rvalid1, d_rvalid1, if_rvalid2, d_rvalid2});
      end
    end
    @(posedge clk);
    #1 if_req = 1'b1; if_addr = 13'd2; d_req = 1'b1; d_addr = 13'd14;
    @(negedge clk);
    total++;
    if ({if_gnt1, d_gnt1, if_gnt2, d_gnt2} !== 4'b1010) begin
      bad++;
      $display("FAIL first_tie_after_reset: got %b want 1010", {if_gnt1, d_gnt1, if_gnt2, d_gnt2});
    end
    push_exp(1'b0, ref_mem[2]);
    drain(5);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    test_reset();
    test_fetch_reads();
    test_data_reads();
    test_back_to_back_tie();
    test_read_after_write();
    test_reset_inflight();
    total++;
    if (q1.size() != 0 || q2.size() != 0) begin
      bad++;
      $display("FAIL leftover_expect: got q1=%0d q2=%0d want 0 0", q1.size(), q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
